bf_data_port: RTL and testbench
===============================

Name: bf_data_port

Overview:
- Data-side server for the brainfuck core, directly downstream of its data port (dp_adr, data_out, data_w_req/sel, data_r_req/sel).
- Routes core accesses to either a single-port synchronous data RAM (sel=0) or the byte I/O channel (sel=1).
- The byte I/O channel has a buffered RX stream for ',' and a buffered TX stream for '.'.
- Generates data_in/data_den and data_w_wait back to the core.

Parameters:
- ADDR_W, 12, data address width (must equal core dp_adr width)
- DATA_W, 8, byte width
- RX_DEPTH, 16, RX FIFO entries, power of two, >= 2
- TX_DEPTH, 16, TX FIFO entries, power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- s_rst  in  1  synchronous soft reset, active-high, same as core s_rst
- dp_adr  in  ADDR_W  core data address
- data_out  in  DATA_W  core write data
- data_w_req  in  1  core write request, level; held while data_w_wait=1
- data_w_sel  in  1  0=RAM write, 1=TX write
- data_w_wait  out  1  combinational stall for the current write
- data_r_req  in  1  core read request, level; held until data_den
- data_r_sel  in  1  0=RAM read, 1=RX read
- data_in  out  DATA_W  read data, valid when data_den=1
- data_den  out  1  single-cycle read-done pulse
- ram_adr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable; ram_rdata is valid 1 cycle later
- ram_rdata  in  DATA_W  RAM read data
- rx_data  in  DATA_W  input byte
- rx_valid  in  1  input byte offered
- rx_ready  out  1  = RX FIFO not full
- tx_data  out  DATA_W  output byte (TX FIFO head)
- tx_valid  out  1  = TX FIFO not empty
- tx_ready  in  1  sink accepts; pop on tx_valid & tx_ready

Behaviour:
- Reset (rst=0, async) or s_rst=1 (sync):
  - FSM to IDLE, both FIFOs emptied.
  - data_den=0, data_in=0, ram_we=0, ram_re=0, ram_adr=0, ram_wdata=0.
  - rx_ready=1 after reset; tx_valid=0.
  - s_rst mid-operation abandons any in-flight read; no data_den is issued.
- FSM states: IDLE, RD_RAM, RD_RX, DONE.
- IDLE:
  - data_r_req & !data_r_sel: ram_re=1 and ram_adr=dp_adr in the same cycle; go to RD_RAM.
  - data_r_req & data_r_sel: go to RD_RX.
- RD_RAM: data_in<=ram_rdata, data_den<=1 next cycle; go to DONE.
  - RAM read latency from request to data_den is 2 cycles.
- RD_RX:
  - Wait while the RX FIFO is empty.
  - When not empty: pop; data_in<=head; data_den<=1 next cycle; go to DONE.
  - Minimum latency is 2 cycles; there is no upper bound.
- DONE: data_den=1 for exactly this cycle; go to IDLE.
  - A data_r_req seen in the cycle after DONE is treated as a new request. The core drops req after den, so this is safe.
- Writes are combinational, accepted in any cycle with data_w_req=1 and data_w_wait=0.
  - sel=0: ram_we=1, ram_adr=dp_adr, ram_wdata=data_out in the same cycle; data_w_wait=0 always.
  - sel=1: data_w_wait = TX FIFO full; when not full, push data_out.
  - One push per cycle of req while not waiting. The core holds req for exactly one accepted cycle.
- Read and write are never concurrent from the core. If both are asserted, the write takes the RAM port and ram_re is deferred one cycle.
- Core MEMI clear (4096 consecutive sel=0 writes) passes straight through as RAM writes, one per cycle.
- RX FIFO:
  - Push on rx_valid & rx_ready.
  - Simultaneous push and pop when full: the pop frees a slot, but rx_ready stays based on the registered full flag (no same-cycle pass-through).
- TX FIFO:
  - Simultaneous push and pop on full is allowed only via data_w_wait, which is computed from the registered full flag.
- FIFO pointers are log2(depth)+1 bits and wrap modulo 2*depth. Counts never exceed depth.

Optional Feature:
- Macro: BF_ECHO_EN.
- Defined: every byte popped in RD_RX is also pushed into the TX FIFO in the same cycle.
  - If the TX FIFO is full, RD_RX stalls (no pop) until there is space.
  - tx order is preserved relative to '.' writes.
- Undefined: no echo; RD_RX ignores the TX FIFO state.

Decomposition:
- Package bf_pkg holds:
  - ADDR_W/DATA_W defaults
  - the bf_port_state_t enum (IDLE, RD_RAM, RD_RX, DONE)
  - opcode constants shared with the core
- One sub-module, bf_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/head), instantiated twice for RX and TX.

Test Plan:
- RAM round-trip: write sel=0 adr=0x005 data=0x41, then read sel=0 adr=0x005 -> data_den exactly 2 cycles after req, data_in=0x41.
- RX stall: read sel=1 with RX empty for 10 cycles, then rx_valid byte 0x7A -> no den during the wait; den 2 cycles after push, data_in=0x7A.
- TX backpressure: tx_ready=0, issue TX_DEPTH+1 writes -> data_w_wait=1 on write 17; raising tx_ready releases it; sink sees all 17 bytes in order.
- RX full: 20 bytes offered with no reads -> rx_ready=0 after 16; reads return bytes 0..15 in order.
- s_rst asserted while in RD_RX with a pending RX byte -> no data_den; FIFOs empty; tx_valid=0 next cycle.
- BF_ECHO_EN: RX byte 0x33 read by core -> data_in=0x33 and tx_data=0x33 with tx_valid=1 the cycle after the pop.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core data side: default widths,
// data-port FSM states and the opcode byte values the core decodes.
package bf_pkg;

    localparam int BF_ADDR_W = 12;
    localparam int BF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_RAM = 2'd1,
        RD_RX  = 2'd2,
        DONE   = 2'd3
    } bf_port_state_t;

    // Source-program opcode bytes (ASCII)
    localparam logic [7:0] OP_INC_PTR = 8'h3E;
    localparam logic [7:0] OP_DEC_PTR = 8'h3C;
    localparam logic [7:0] OP_INC     = 8'h2B;
    localparam logic [7:0] OP_DEC     = 8'h2D;
    localparam logic [7:0] OP_OUT     = 8'h2E;
    localparam logic [7:0] OP_IN      = 8'h2C;
    localparam logic [7:0] OP_JZ      = 8'h5B;
    localparam logic [7:0] OP_JNZ     = 8'h5D;

endpackage

// File: rtl/bf_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a combinational head view.
// full/empty derive only from the registered pointers.
module bf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign head    = mem[rd_ptr_reg[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

endmodule

// File: rtl/bf_data_port.sv
// Data-side server for the brainfuck core: RAM (sel=0) or byte I/O (sel=1).
// Define BF_ECHO_EN to copy every RX byte read by the core into the TX stream.
module bf_data_port
    import bf_pkg::*;
#(
    parameter int ADDR_W   = BF_ADDR_W,
    parameter int DATA_W   = BF_DATA_W,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_rst,
    input  logic [ADDR_W-1:0] dp_adr,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_w_req,
    input  logic              data_w_sel,
    output logic              data_w_wait,
    input  logic              data_r_req,
    input  logic              data_r_sel,
    output logic [DATA_W-1:0] data_in,
    output logic              data_den,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
    bf_port_state_t    state_reg, state_next;
    logic [DATA_W-1:0] data_in_reg, data_in_next;
    logic              data_den_reg, data_den_next;

    logic              rx_full, rx_empty, rx_take, rx_can_pop;
    logic [DATA_W-1:0] rx_head;
    logic              tx_full, tx_empty, tx_push;
    logic [DATA_W-1:0] tx_push_data;
    logic              ram_wr, tx_wr_req;

    assign ram_wr      = data_w_req & ~data_w_sel & ~s_rst;
    assign tx_wr_req   = data_w_req & data_w_sel & ~s_rst;
    assign data_w_wait = tx_wr_req & tx_full;

    assign ram_we    = ram_wr;
    assign ram_wdata = ram_wr ? data_out : '0;
    assign ram_adr   = (ram_wr | ram_re) ? dp_adr : '0;

    assign rx_take = (state_reg == RD_RX) & ~rx_empty & rx_can_pop & ~s_rst;

`ifdef BF_ECHO_EN
    // The echo shares the TX push port, so a pop waits for TX space.
    assign rx_can_pop   = ~tx_full & ~tx_wr_req;
    assign tx_push      = (tx_wr_req & ~tx_full) | rx_take;
    assign tx_push_data = rx_take ? rx_head : data_out;
`else
    assign rx_can_pop   = 1'b1;
    assign tx_push      = tx_wr_req & ~tx_full;
    assign tx_push_data = data_out;
`endif

    always_comb begin
        state_next    = state_reg;
        data_in_next  = data_in_reg;
        data_den_next = 1'b0;
        ram_re        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (data_r_req && !s_rst) begin
                    if (data_r_sel) begin
                        state_next = RD_RX;
                    end else if (!ram_wr) begin
                        ram_re     = 1'b1;
                        state_next = RD_RAM;
                    end
                end
            end
            RD_RAM: begin
                data_in_next  = ram_rdata;
                data_den_next = 1'b1;
                state_next    = DONE;
            end
            RD_RX: begin
                if (rx_take) begin
                    data_in_next  = rx_head;
                    data_den_next = 1'b1;
                    state_next    = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            data_in_reg  <= '0;
            data_den_reg <= 1'b0;
        end else if (s_rst) begin
            state_reg    <= IDLE;
            data_in_reg  <= '0;
            data_den_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_in_reg  <= data_in_next;
            data_den_reg <= data_den_next;
        end
    end

    assign data_in  = data_in_reg;
    assign data_den = data_den_reg;

    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;

    bf_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (s_rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_take),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    bf_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (s_rst),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_ready),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_data)
    );

endmodule

// File: tb/tb_bf_data_port.sv
// Directed bench for bf_data_port: RAM round-trips, RX stall/full, TX
// backpressure, soft reset and (with BF_ECHO_EN) the RX-to-TX echo.
module tb_bf_data_port;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst, s_rst;
    logic [ADDR_W-1:0] dp_adr;
    logic [DATA_W-1:0] data_out;
    logic              data_w_req, data_w_sel, data_w_wait;
    logic              data_r_req, data_r_sel;
    logic [DATA_W-1:0] data_in;
    logic              data_den;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid, tx_ready;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] ram_mem [4096];
    logic [DATA_W-1:0] tx_q [$];

    always #5 clk = ~clk;

    bf_data_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .s_rst(s_rst),
        .dp_adr(dp_adr), .data_out(data_out),
        .data_w_req(data_w_req), .data_w_sel(data_w_sel), .data_w_wait(data_w_wait),
        .data_r_req(data_r_req), .data_r_sel(data_r_sel),
        .data_in(data_in), .data_den(data_den),
        .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // External synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_adr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram_mem[ram_adr];
    end

    // TX sink: a byte is taken at the edge following a cycle with valid & ready
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller sits at a negedge; returns cycles elapsed until data_den is seen.
    task automatic wait_den(input int max_cyc, output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        while (lat < max_cyc) begin
            if (data_den === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; s_rst = 1'b0;
        dp_adr = '0; data_out = '0;
        data_w_req = 1'b0; data_w_sel = 1'b0;
        data_r_req = 1'b0; data_r_sel = 1'b0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL reset_den: got %0b want 0", data_den); end
        checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in: got %02h want 00", data_in); end
        checks++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got we=%0b re=%0b want 0/0", ram_we, ram_re); end
        checks++; if (ram_adr !== 12'h000 || ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_bus: got adr=%03h wdata=%02h want 000/00", ram_adr, ram_wdata); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %0b want 1", rx_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0b want 0", tx_valid); end
        tick();
        rst = 1'b1;
        tick();
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_ram_roundtrip();
        logic [ADDR_W-1:0] adrs [2];
        logic [DATA_W-1:0] dats [2];
        bit seen;
        int lat;
        adrs[0] = 12'h005; dats[0] = 8'h41;
        adrs[1] = 12'hFFF; dats[1] = 8'hA5;
        for (int v = 0; v < 2; v++) begin
            tick();
            data_w_req = 1'b1; data_w_sel = 1'b0; dp_adr = adrs[v]; data_out = dats[v];
            @(negedge clk);
            checks++; if (ram_we !== 1'b1 || ram_adr !== adrs[v] || ram_wdata !== dats[v] || data_w_wait !== 1'b0)
                begin errors++; $display("FAIL ram_write: got we=%0b adr=%03h wd=%02h wait=%0b want 1/%03h/%02h/0", ram_we, ram_adr, ram_wdata, data_w_wait, adrs[v], dats[v]); end
            tick();
            data_w_req = 1'b0; data_r_req = 1'b1; data_r_sel = 1'b0;
            @(negedge clk);
            checks++; if (ram_re !== 1'b1 || ram_adr !== adrs[v])
                begin errors++; $display("FAIL ram_read_issue: got re=%0b adr=%03h want 1/%03h", ram_re, ram_adr, adrs[v]); end
            wait_den(6, seen, lat);
            checks++; if (!seen || lat != 2) begin errors++; $display("FAIL ram_read_latency: got seen=%0b lat=%0d want 1/2", seen, lat); end
            checks++; if (data_in !== dats[v]) begin errors++; $display("FAIL ram_read_data: got %02h want %02h", data_in, dats[v]); end
            tick();
            data_r_req = 1'b0;
            @(negedge clk);
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL ram_den_pulse: got %0b want 0", data_den); end
            $display("ram round-trip adr=%03h data=%02h latency=%0d", adrs[v], data_in, lat);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int lat;
        for (int i = 0; i < 8; i++) begin
            tick();
            data_w_req = 1'b1; data_w_sel = 1'b0;
            dp_adr = 12'h100 + 12'(i); data_out = 8'h80 + 8'(i);
            @(negedge clk);
            checks++; if (ram_we !== 1'b1 || ram_adr !== 12'h100 + 12'(i) || ram_wdata !== 8'h80 + 8'(i))
                begin errors++; $display("FAIL b2b_write: got we=%0b adr=%03h wd=%02h want 1/%03h/%02h", ram_we, ram_adr, ram_wdata, 12'h100 + 12'(i), 8'h80 + 8'(i)); end
        end
        // Write and read raised together: write wins, read follows a cycle later
        tick();
        dp_adr = 12'h103; data_out = 8'hC3; data_r_req = 1'b1; data_r_sel = 1'b0;
        @(negedge clk);
        checks++; if (ram_we !== 1'b1 || ram_re !== 1'b0) begin errors++; $display("FAIL conflict_write_first: got we=%0b re=%0b want 1/0", ram_we, ram_re); end
        tick();
        data_w_req = 1'b0;
        @(negedge clk);
        checks++; if (ram_re !== 1'b1 || ram_adr !== 12'h103) begin errors++; $display("FAIL conflict_read_deferred: got re=%0b adr=%03h want 1/103", ram_re, ram_adr); end
        wait_den(6, seen, lat);
        checks++; if (!seen || data_in !== 8'hC3) begin errors++; $display("FAIL conflict_read_data: got seen=%0b data=%02h want 1/c3", seen, data_in); end
        tick();
        data_r_req = 1'b0;
        tick();
        dp_adr = 12'h105; data_r_req = 1'b1;
        @(negedge clk);
        wait_den(6, seen, lat);
        checks++; if (!seen || data_in !== 8'h85) begin errors++; $display("FAIL b2b_readback: got seen=%0b data=%02h want 1/85", seen, data_in); end
        tick();
        data_r_req = 1'b0;
        $display("back-to-back writes done, readback 105=%02h", data_in);
    endtask

    task automatic test_rx_stall();
        tick();
        data_r_req = 1'b1; data_r_sel = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL rx_stall_no_den: cycle %0d got %0b want 0", k, data_den); end
            tick();
        end
        rx_valid = 1'b1; rx_data = 8'h7A;
        @(negedge clk);
        checks++; if (rx_ready !== 1'b1 || data_den !== 1'b0) begin errors++; $display("FAIL rx_stall_push: got ready=%0b den=%0b want 1/0", rx_ready, data_den); end
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL rx_stall_early_den: got %0b want 0", data_den); end
        tick();
        @(negedge clk);
        checks++; if (data_den !== 1'b1 || data_in !== 8'h7A) begin errors++; $display("FAIL rx_stall_read: got den=%0b data=%02h want 1/7a", data_den, data_in); end
        tick();
        data_r_req = 1'b0;
        @(negedge clk);
        checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL rx_stall_den_pulse: got %0b want 0", data_den); end
        $display("rx stall read data=7a observed");
    endtask

    task automatic test_tx_backpressure();
        int k;
        tx_q.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            data_w_req = 1'b1; data_w_sel = 1'b1; data_out = 8'h10 + 8'(i);
            @(negedge clk);
            checks++; if (data_w_wait !== (i == 16)) begin errors++; $display("FAIL tx_wait_write%0d: got %0b want %0b", i, data_w_wait, (i == 16)); end
        end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin errors++; $display("FAIL tx_head: got valid=%0b data=%02h want 1/10", tx_valid, tx_data); end
        repeat (2) begin
            tick();
            @(negedge clk);
            checks++; if (data_w_wait !== 1'b1) begin errors++; $display("FAIL tx_wait_hold: got %0b want 1", data_w_wait); end
        end
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (data_w_wait !== 1'b1) begin errors++; $display("FAIL tx_wait_registered_full: got %0b want 1", data_w_wait); end
        tick();
        @(negedge clk);
        checks++; if (data_w_wait !== 1'b0) begin errors++; $display("FAIL tx_wait_release: got %0b want 0", data_w_wait); end
        tick();
        data_w_req = 1'b0;
        k = 0;
        while (tx_q.size() < 17 && k < 40) begin
            tick();
            k++;
        end
        checks++; if (tx_q.size() != 17) begin errors++; $display("FAIL tx_sink_count: got %0d want 17", tx_q.size()); end
        for (int i = 0; i < 17 && i < tx_q.size(); i++) begin
            checks++; if (tx_q[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL tx_sink_byte%0d: got %02h want %02h", i, tx_q[i], 8'h10 + 8'(i)); end
        end
        $display("tx backpressure: sink received %0d bytes", tx_q.size());
    endtask

    task automatic test_rx_full();
        bit seen;
        int lat;
        for (int i = 0; i < 20; i++) begin
            tick();
            rx_valid = 1'b1; rx_data = 8'(i);
            @(negedge clk);
            checks++; if (rx_ready !== (i < 16)) begin errors++; $display("FAIL rx_ready_offer%0d: got %0b want %0b", i, rx_ready, (i < 16)); end
        end
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_r_req = 1'b1; data_r_sel = 1'b1;
            @(negedge clk);
            wait_den(8, seen, lat);
            checks++; if (!seen || lat != 2 || data_in !== 8'(i)) begin errors++; $display("FAIL rx_full_read%0d: got seen=%0b lat=%0d data=%02h want 1/2/%02h", i, seen, lat, data_in, 8'(i)); end
            tick();
            data_r_req = 1'b0;
            tick();
        end
        @(negedge clk);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after_drain: got %0b want 1", rx_ready); end
        $display("rx full: 16 bytes read back in order, last=%02h", data_in);
    endtask

    task automatic test_srst();
        tick();
        tx_ready = 1'b0;
        data_w_req = 1'b1; data_w_sel = 1'b1; data_out = 8'h99;
        tick();
        data_w_req = 1'b0; data_r_req = 1'b1; data_r_sel = 1'b1;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL srst_tx_loaded: got %0b want 1", tx_valid); end
        tick();
        tick();
        s_rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL srst_den_during: got %0b want 0", data_den); end
        tick();
        s_rst = 1'b0; rx_valid = 1'b0; data_r_req = 1'b0;
        @(negedge clk);
        checks++; if (data_den !== 1'b0 || data_in !== 8'h00) begin errors++; $display("FAIL srst_outputs: got den=%0b data=%02h want 0/00", data_den, data_in); end
        checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL srst_fifos: got tx_valid=%0b rx_ready=%0b want 0/1", tx_valid, rx_ready); end
        repeat (3) begin
            tick();
            @(negedge clk);
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL srst_late_den: got %0b want 0", data_den); end
        end
        // RX must be empty now: a fresh RX read has to stall
        tick();
        data_r_req = 1'b1; data_r_sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (data_den !== 1'b0) begin errors++; $display("FAIL srst_rx_empty: cycle %0d got den=%0b want 0", k, data_den); end
            tick();
        end
        s_rst = 1'b1; data_r_req = 1'b0;
        tick();
        s_rst = 1'b0;
        $display("soft reset: in-flight RX read abandoned");
    endtask

`ifdef BF_ECHO_EN
    task automatic test_echo();
        bit seen;
        int lat;
        tx_q.delete();
        tx_ready = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h33;
        tick();
        rx_valid = 1'b0; data_r_req = 1'b1; data_r_sel = 1'b1;
        @(negedge clk);
        wait_den(8, seen, lat);
        checks++; if (!seen || data_in !== 8'h33) begin errors++; $display("FAIL echo_read: got seen=%0b data=%02h want 1/33", seen, data_in); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin errors++; $display("FAIL echo_tx: got valid=%0b data=%02h want 1/33", tx_valid, tx_data); end
        tick();
        data_r_req = 1'b0;
        $display("echo: rx 33 forwarded to tx");
    endtask
`endif

    initial begin
        test_reset();
        test_ram_roundtrip();
        test_back_to_back();
        test_rx_stall();
        test_tx_backpressure();
        test_rx_full();
        test_srst();
`ifdef BF_ECHO_EN
        test_echo();
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
